// File: rtl/rf_wr_port_arbiter.sv
// Register-file write-port arbiter: writeback has priority, multi-cycle
// results queue in a small FIFO and drain into idle write-port cycles.
module rf_wr_port_arbiter #(
  parameter int BIT_WIDTH    = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_wr,
  input  logic [4:0]             wb_reg,
  input  logic [BIT_WIDTH-1:0]   wb_data,
  input  logic                   mc_valid,
  input  logic [4:0]             mc_reg,
  input  logic [BIT_WIDTH-1:0]   mc_data,
  output logic                   mc_ready,
  output logic                   rf_wr,
  output logic [4:0]             rf_reg,
  output logic [BIT_WIDTH-1:0]   rf_data,
  output logic                   wb_stall,
  input  logic [4:0]             chk_reg1,
  input  logic [4:0]             chk_reg2,
  output logic                   chk_busy1,
  output logic                   chk_busy2,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_STALL  = 1'b1;

  logic [4:0]           r_mem_reg  [DEPTH];
  logic [BIT_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_count;
  logic [SW-1:0]        r_starve;
  logic [0:0]           r_state;

  logic          w_pipe;
  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [SW-1:0] w_starve_nxt;
  logic [PW-1:0] w_off;

  assign w_nonempty = (r_count != '0);
  assign mc_ready   = (r_count < FULL);
  assign w_pipe     = wb_wr && (wb_reg != 5'd0);
  // Register 0 writes are accepted but dropped, never occupying a slot.
  assign w_push     = mc_valid && mc_ready && (mc_reg != 5'd0);
  assign w_pop      = !w_pipe && w_nonempty;
  assign fifo_count = r_count;
  assign wb_stall   = (r_state == ST_STALL);

  always_comb begin
    rf_wr   = 1'b0;
    rf_reg  = 5'd0;
    rf_data = '0;
    if (w_pipe) begin
      rf_wr   = 1'b1;
      rf_reg  = wb_reg;
      rf_data = wb_data;
    end else if (w_nonempty) begin
      rf_wr   = 1'b1;
      rf_reg  = r_mem_reg[r_rd_ptr];
      rf_data = r_mem_data[r_rd_ptr];
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || !w_nonempty)
      w_starve_nxt = '0;
    else if (w_pipe && r_starve != LIMIT)
      w_starve_nxt = r_starve + 1'b1;
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    chk_busy1 = 1'b0;
    chk_busy2 = 1'b0;
    w_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if ({1'b0, w_off} < r_count) begin
        if (r_mem_reg[i] == chk_reg1 && chk_reg1 != 5'd0)
          chk_busy1 = 1'b1;
        if (r_mem_reg[i] == chk_reg2 && chk_reg2 != 5'd0)
          chk_busy2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= mc_reg;
      r_mem_data[r_wr_ptr] <= mc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
      r_state  <= ST_NORMAL;
    end else begin
      r_starve <= w_starve_nxt;
      unique case (r_state)
        ST_NORMAL:
          if (w_starve_nxt == LIMIT)
            r_state <= ST_STALL;
        ST_STALL:
          if (w_pop)
            r_state <= ST_NORMAL;
        default:
          r_state <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Directed bench for rf_wr_port_arbiter: priority, drain order, full FIFO,
// starvation stall, reg-0 handling, hazard lookup and async reset.
module tb_rf_wr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wr;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_wr;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic        wb_stall;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic [2:0]  fifo_count;

  int n_chk = 0;
  int n_err = 0;

  rf_wr_port_arbiter #(
    .BIT_WIDTH(32), .DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_wr(wb_wr), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
    .mc_ready(mc_ready),
    .rf_wr(rf_wr), .rf_reg(rf_reg), .rf_data(rf_data),
    .wb_stall(wb_stall),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_wr = 0; wb_reg = 0; wb_data = 0;
    mc_valid = 0; mc_reg = 0; mc_data = 0;
    chk_reg1 = 0; chk_reg2 = 0;
    #12 rst = 1'b0;
    step();
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", mc_ready, 1);
    chk("rst_rfwr", rf_wr, 0);
    chk("rst_stall", wb_stall, 0);

    // priority and drain
    wb_wr = 1; wb_reg = 7; wb_data = 32'h11;
    mc_valid = 1; mc_reg = 5; mc_data = 32'hAAAA_0001;
    chk_reg1 = 5;
    settle();
    chk("pri0_reg", rf_reg, 7);
    chk("push_invisible", chk_busy1, 0);
    step();
    mc_valid = 0;
    settle();
    chk("pri1_reg", rf_reg, 7);
    chk("pri1_data", rf_data, 32'h11);
    chk("pri1_count", fifo_count, 1);
    chk("pri1_busy", chk_busy1, 1);
    step();
    wb_wr = 0;
    settle();
    chk("drain_wr", rf_wr, 1);
    chk("drain_reg", rf_reg, 5);
    chk("drain_data", rf_data, 32'hAAAA_0001);
    step();
    chk("drain_count", fifo_count, 0);
    chk("drain_idle", rf_wr, 0);
    chk("drain_rfreg", rf_reg, 0);

    // full FIFO with wrap
    wb_wr = 1; wb_reg = 7;
    mc_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      mc_reg = 5'(i); mc_data = 32'h100 + i;
      step();
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", mc_ready, 0);
    mc_reg = 5; mc_data = 32'h105;
    step();
    chk("held_count", fifo_count, 4);
    wb_wr = 0;
    settle();
    chk("full_pop_ready", mc_ready, 0);
    chk("full_pop_reg", rf_reg, 1);
    chk("full_pop_data", rf_data, 32'h101);
    step();
    chk("refused_count", fifo_count, 3);
    chk("late_ready", mc_ready, 1);
    chk("d2_reg", rf_reg, 2);
    step();
    mc_valid = 0;
    chk("pushpop_count", fifo_count, 3);
    for (int i = 3; i <= 5; i++) begin
      chk("order_reg", rf_reg, i);
      chk("order_data", rf_data, 32'h100 + i);
      step();
    end
    chk("full_empty", fifo_count, 0);

    // starvation
    wb_wr = 1; wb_reg = 3; wb_data = 32'h33;
    mc_valid = 1; mc_reg = 10; mc_data = 32'hBEEF;
    step();
    mc_valid = 0;
    for (int i = 0; i < 7; i++) step();
    chk("stall_early", wb_stall, 0);
    step();
    chk("stall_set", wb_stall, 1);
    chk("stall_denied", rf_reg, 3);
    wb_wr = 0;
    settle();
    chk("stall_drain_reg", rf_reg, 10);
    chk("stall_drain_data", rf_data, 32'hBEEF);
    chk("stall_hold", wb_stall, 1);
    step();
    chk("stall_clear", wb_stall, 0);
    chk("stall_count", fifo_count, 0);

    // reg-0 handling
    mc_valid = 1; mc_reg = 0; mc_data = 32'hDEAD;
    step();
    chk("r0_count", fifo_count, 0);
    chk("r0_nowr", rf_wr, 0);
    wb_wr = 1; wb_reg = 3;
    mc_reg = 9; mc_data = 32'h99;
    step();
    mc_valid = 0;
    wb_reg = 0;
    settle();
    chk("wb0_wr", rf_wr, 1);
    chk("wb0_reg", rf_reg, 9);
    chk("wb0_data", rf_data, 32'h99);
    step();
    chk("wb0_count", fifo_count, 0);

    // hazard lookup
    wb_wr = 1; wb_reg = 3;
    mc_valid = 1; mc_reg = 12; mc_data = 32'hC;
    step();
    mc_reg = 20; mc_data = 32'h14;
    step();
    mc_valid = 0;
    chk_reg1 = 12; chk_reg2 = 13;
    settle();
    chk("hz_busy1", chk_busy1, 1);
    chk("hz_busy2", chk_busy2, 0);
    chk_reg2 = 20;
    settle();
    chk("hz_busy2b", chk_busy2, 1);
    wb_wr = 0;
    step();
    chk("hz_popped", chk_busy1, 0);
    chk("hz_remain", chk_busy2, 1);
    chk_reg1 = 0;
    settle();
    chk("hz_zero", chk_busy1, 0);
    step();
    chk("hz_empty", fifo_count, 0);

    // async reset with 3 entries queued
    wb_wr = 1; wb_reg = 3;
    mc_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      mc_reg = 5'(20 + i); mc_data = 32'h200 + i;
      step();
    end
    mc_valid = 0;
    chk("ar_pre_count", fifo_count, 3);
    #2;
    wb_wr = 0;
    rst = 1'b1;
    #1;
    chk("ar_count", fifo_count, 0);
    chk("ar_ready", mc_ready, 1);
    chk("ar_rfwr", rf_wr, 0);
    chk("ar_stall", wb_stall, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_nostale", rf_wr, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_port_arbiter.md
Name: rf_wr_port_arbiter

Overview:
Shares the register file's single write port between two writers. The pipeline writeback stage has fixed priority and no backpressure. A multi-cycle execution unit (divider/multiplier) uses a valid/ready handshake. Multi-cycle results wait in a small FIFO and drain into idle write-port cycles. If they are starved too long, the block requests a one-bubble writeback stall. Decode gets a per-register pending-write lookup for hazard stalls.

Parameters:
BIT_WIDTH, 32, data width; matches the register file.
DEPTH, 4, FIFO entries for multi-cycle results; power of 2, at least 2.
STARVE_LIMIT, 8, consecutive denied cycles with a non-empty FIFO before wb_stall asserts; at least 1.

Ports:
clk  in  1  clock
rst  in  1  reset
wb_wr  in  1  pipeline writeback enable
wb_reg  in  5  pipeline destination register
wb_data  in  BIT_WIDTH  pipeline write data
mc_valid  in  1  multi-cycle result valid
mc_reg  in  5  multi-cycle destination register
mc_data  in  BIT_WIDTH  multi-cycle result data
mc_ready  out  1  FIFO can accept
rf_wr  out  1  to register file reg_wr
rf_reg  out  5  to register file wr_reg
rf_data  out  BIT_WIDTH  to register file wr_data
wb_stall  out  1  request: pipeline inserts a writeback bubble
chk_reg1  in  5  decode source register 1
chk_reg2  in  5  decode source register 2
chk_busy1  out  1  pending FIFO write to chk_reg1
chk_busy2  out  1  pending FIFO write to chk_reg2
fifo_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
Reset and interface
- Reset: rst is asynchronous, active-high; clock is clk.
- On rst, all of the following clear to 0: the FIFO (pointers and count), starve_cnt, the FSM (to NORMAL) and wb_stall.
- With an empty FIFO and wb_wr=0, the rf_* outputs are 0.
- Reset mid-operation discards all pending entries; no write is issued for them.

FIFO accept
- mc_ready = (count < DEPTH). It depends on count only, so a full FIFO refuses a push even in a cycle where it pops.
- Accept occurs on mc_valid && mc_ready at a clk edge.
- An accepted entry with mc_reg=0 is consumed and not stored; count is unchanged.

Write-port grant (combinational, same cycle)
- pipe_active = wb_wr && wb_reg != 0.
- pipe_active: rf_wr=1, rf_reg=wb_reg, rf_data=wb_data.
- Else if count > 0: drive the FIFO head and pop it at the edge.
- Else: rf_wr=0, rf_reg=0, rf_data=0.
- wb_wr=1 with wb_reg=0 counts as idle and the FIFO may drain.
- Latency: an accepted mc entry is written no earlier than the cycle after acceptance. Entries drain in FIFO order.
- Push and pop in the same cycle are both performed; count is unchanged.
- Pointers wrap modulo DEPTH.

Starvation FSM (states NORMAL, STALL)
- starve_cnt increments (saturating at STARVE_LIMIT) each cycle with count > 0 && pipe_active.
- starve_cnt clears on any pop, or when count = 0.
- NORMAL -> STALL at the edge where starve_cnt reaches STARVE_LIMIT. wb_stall is registered and is 1 exactly in STALL.
- STALL -> NORMAL at the edge of a pop. wb_stall drops the following cycle.
- Pipeline contract: in the cycle after wb_stall first reads 1, wb_wr=0.
- If the pipeline violates the contract, it still wins the port and STALL persists.

Hazard lookup (combinational)
- chk_busyN = 1 iff a valid FIFO entry has reg == chk_regN and chk_regN != 0.
- The entry being pushed in the current cycle is not visible until the next cycle.
- Decode must not issue a pipeline write to a busy register. The arbiter never reorders writes and does not resolve same-register races.

Test Plan:
- Reset/idle: assert rst mid-cycle (async) with the FIFO holding 3 entries -> immediately count=0, mc_ready=1, rf_wr=0, wb_stall=0; after release, no stale writes occur.
- Priority and drain: push reg5=0xAAAA_0001 while wb_wr=1 (reg7=0x11) for 2 cycles -> rf_reg=7 both cycles. Then wb_wr=0 -> rf_wr=1, rf_reg=5, rf_data=0xAAAA_0001, count goes 1->0.
- Full FIFO: push 5 results with wb_wr held high -> mc_ready=0 after the 4th accept and the 5th is held. Drop wb_wr with mc_valid still high -> pop and count 4->3, with the push refused that cycle; the 5th is accepted the next cycle. Entries drain in order with the wrap verified.
- Starvation: 1 entry queued, wb_wr=1 to reg3 continuously -> wb_stall=1 after 8 denied cycles. The bench drops wb_wr the next cycle -> FIFO entry written, then wb_stall=0 one cycle later.
- Reg-0 handling: mc push to reg0 -> count stays 0, no write. wb_wr=1 with wb_reg=0 while the FIFO holds reg9 -> reg9 written that cycle.
- Hazard lookup: FIFO holds reg12 and reg20; chk_reg1=12, chk_reg2=13 -> busy1=1, busy2=0. After reg12 pops -> busy1=0. chk_reg=0 -> busy=0.
